memory_verify_fsm: RTL
======================

// Module: memory_verify_fsm
// PURPOSE
//  Downstream consumer of the RAM init stage. On the rising edge of init_finish it sweeps
//  addresses FIRST_ADDR..LAST_ADDR of the same on-chip RAM over the read port.
//  Each word is checked against the init pattern (data == address[DATA_W-1:0]).
//  Reports a 16-bit checksum, the mismatch count, the first bad address and pass/done.
//  A retest request is forwarded upstream as a one-cycle restart pulse.
// PARAMETERS
//  ADDR_W      10    RAM address width
//  DATA_W      8     RAM data width
//  FIRST_ADDR  1     first address checked
//  LAST_ADDR   255   last address checked (inclusive); FIRST_ADDR <= LAST_ADDR
//  RD_LATENCY  1     RAM read latency in cycles (1 or 2)
// PORTS
//  clk            in   1       system clock
//  reset_n        in   1       asynchronous active-low reset
//  init_finish    in   1       level from init stage; rising edge starts a sweep
//  retest         in   1       pulse; honoured only in DONE
//  rd_address     out  ADDR_W  RAM read address
//  rd_data        in   DATA_W  RAM q, valid RD_LATENCY cycles after rd_address
//  restart        out  1       1-cycle pulse to init stage restart input
//  busy           out  1       sweep in progress (ISSUE or DRAIN)
//  done           out  1       results valid (DONE state)
//  pass           out  1       done && mismatch_count==0
//  abort          out  1       1-cycle pulse: sweep aborted by init_finish falling
//  checksum       out  16      sum of all read words, zero-extended, modulo 2^16
//  mismatch_count out  ADDR_W  words with data != addr[DATA_W-1:0], saturating at all-ones
//  first_bad_addr out  ADDR_W  address of first mismatch; all-ones if none
// BEHAVIOUR
//  Reset: state IDLE; rd_address=FIRST_ADDR; restart=busy=done=pass=abort=0;
//    checksum=0; mismatch_count=0; first_bad_addr=all-ones; init_finish edge register=0.
//  IDLE: on init_finish rising edge (registered prev=0, now=1), clear checksum, mismatch_count
//    and first_bad_addr; load rd_address=FIRST_ADDR; go to ISSUE.
//  ISSUE: present one address per cycle. Push {valid, addr} into the tag pipe.
//    After LAST_ADDR is presented, go to DRAIN. rd_address then holds LAST_ADDR.
//  DRAIN: wait exactly RD_LATENCY cycles for the remaining returns, then go to DONE.
//  Compare: when the tag pipe output is valid, sample rd_data against the tagged addr.
//    checksum += rd_data. On mismatch, mismatch_count increments (saturating).
//    first_bad_addr is written only if it is still all-ones.
//  Sweep length: N = LAST_ADDR-FIRST_ADDR+1 cycles in ISSUE. busy spans N+RD_LATENCY cycles.
//    done rises the cycle after the last compare.
//  DONE: outputs hold. On retest: restart=1 for one cycle, done/pass clear, go to IDLE.
//    The next sweep starts on the next init_finish rising edge.
//    init_finish must be seen low first; the init stage drops it on restart.
//  Abort: init_finish low during ISSUE or DRAIN -> abort pulse, tag pipe flushed, go to IDLE.
//    Partial checksum and counts are held; done stays 0.
//  Simultaneous events: retest outside DONE is ignored. A rising edge while busy is impossible
//    (level already high). Abort takes priority over the last compare.
//  Reset mid-sweep: immediate return to reset values; no restart pulse.
//  Widths: checksum adder is 16-bit wrap. The comparison uses addr[DATA_W-1:0] only,
//    so addresses above 2^DATA_W alias the pattern.
// STRUCTURE
//  Package mem_check_pkg: state enum {IDLE, ISSUE, DRAIN, DONE}; CHK_W=16;
//    NO_BAD_ADDR (all-ones) constant.
//  Sub-module rd_tag_pipe: RD_LATENCY-deep shift register of {valid, addr}.
//    Has a synchronous flush input; provides the aligned compare address.
//  Top: FSM, address counter, edge detector, compare/accumulate datapath.
// TESTING
//  RAM model preloaded with init pattern, addr 1..255, RD_LATENCY=1 -> busy 256 cycles;
//    done=1, pass=1, mismatch_count=0, checksum=16'h7F80, first_bad_addr=10'h3FF.
//  Corrupt addr 0x10 to 0xAA and addr 0x80 to 0x00 -> mismatch_count=2,
//    first_bad_addr=10'h010, pass=0, checksum=16'h7F80+0x9A-0x80=16'h7F9A.
//  RD_LATENCY=2, clean RAM -> same results as the first test; busy spans 257 cycles.
//    No off-by-one compare: each word is checked against its own address.
//  Drop init_finish at addr 0x40 -> abort pulse 1 cycle, done=0, IDLE.
//    Next rising edge -> full clean sweep, pass=1.
//  In DONE, pulse retest -> restart high exactly 1 cycle, done=0.
//    retest pulsed during ISSUE -> no restart.
//  Assert reset_n mid-ISSUE -> all outputs at reset values asynchronously.
//    No sweep restarts until init_finish goes low then high.

Source files
------------

// File: rtl/mem_check_pkg.sv
// Shared types and constants for the memory verify stage.
//   state_t     : sweep controller states
//   CHK_W       : checksum width
//   NO_BAD_ADDR : "no mismatch seen" marker, sliced to the address width by users
package mem_check_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int          CHK_W       = 16;
    localparam logic [31:0] NO_BAD_ADDR = 32'hFFFF_FFFF;

endpackage

// File: rtl/memory_verify_fsm_if.sv
// Bundle between the verify stage, the RAM read port and the init stage.
//   master : the verify stage (drives read address, restart pulse and results)
//   slave  : the environment (RAM q, init_finish level, retest pulse)
interface memory_verify_fsm_if
    import mem_check_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
);
    logic              init_finish;
    logic              retest;
    logic [ADDR_W-1:0] rd_address;
    logic [DATA_W-1:0] rd_data;
    logic              restart;
    logic              busy;
    logic              done;
    logic              pass;
    logic              abort;
    logic [CHK_W-1:0]  checksum;
    logic [ADDR_W-1:0] mismatch_count;
    logic [ADDR_W-1:0] first_bad_addr;

    modport master (
        input  init_finish, retest, rd_data,
        output rd_address, restart, busy, done, pass, abort,
               checksum, mismatch_count, first_bad_addr
    );

    modport slave (
        output init_finish, retest, rd_data,
        input  rd_address, restart, busy, done, pass, abort,
               checksum, mismatch_count, first_bad_addr
    );
endinterface

// File: rtl/rd_tag_pipe.sv
// Shift register that travels alongside the RAM read latency so each returning
// word can be matched with the address that produced it.
//   clk, reset_n  : clock, asynchronous active-low reset (valid bits only)
//   flush_i       : synchronous clear of every in-flight tag
//   push_vld_i/
//   push_addr_i   : tag entering with the address presented this cycle
//   out_vld_o/
//   out_addr_o    : tag aligned with the RAM q of the current cycle
module rd_tag_pipe
    import mem_check_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush_i,
    input  logic              push_vld_i,
    input  logic [ADDR_W-1:0] push_addr_i,
    output logic              out_vld_o,
    output logic [ADDR_W-1:0] out_addr_o
);

    logic [DEPTH-1:0]  vld_q;
    logic [ADDR_W-1:0] addr_q [DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= '0;
        end else if (flush_i) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= push_vld_i;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    // Address bits are qualified by vld_q, so they need no reset.
    always_ff @(posedge clk) begin
        addr_q[0] <= push_addr_i;
        for (int i = 1; i < DEPTH; i++) begin
            addr_q[i] <= addr_q[i-1];
        end
    end

    assign out_vld_o  = vld_q[DEPTH-1];
    assign out_addr_o = addr_q[DEPTH-1];

endmodule

// File: rtl/memory_verify_fsm.sv
// Post-init RAM checker. On a rising edge of init_finish it reads
// FIRST_ADDR..LAST_ADDR, compares every word with addr[DATA_W-1:0], and reports
// checksum, mismatch count, first bad address and pass/done. retest in DONE
// sends a one-cycle restart pulse to the init stage.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : memory_verify_fsm_if.master (RAM read port, init handshake, results)
module memory_verify_fsm
    import mem_check_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 8,
    parameter int FIRST_ADDR = 1,
    parameter int LAST_ADDR  = 255,
    parameter int RD_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    memory_verify_fsm_if.master bus
);

    localparam logic [ADDR_W-1:0] FIRST_A    = ADDR_W'(FIRST_ADDR);
    localparam logic [ADDR_W-1:0] LAST_A     = ADDR_W'(LAST_ADDR);
    localparam logic [ADDR_W-1:0] NO_BAD     = NO_BAD_ADDR[ADDR_W-1:0];
    localparam logic [1:0]        DRAIN_LAST = 2'(RD_LATENCY - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        drain_q, drain_d;
    logic              init_q;
    logic              armed_q;
    logic              restart_q;
    logic              abort_q;
    logic [CHK_W-1:0]  sum_q;
    logic [ADDR_W-1:0] mis_q;
    logic [ADDR_W-1:0] bad_q;

    logic              rise;
    logic              abort_now;
    logic              tag_vld;
    logic [ADDR_W-1:0] tag_addr;
    logic              busy, done;

    // armed_q keeps a level that was already high across reset from looking
    // like a fresh edge: init_finish has to be seen low once before a sweep.
    assign rise      = bus.init_finish & ~init_q & armed_q;
    assign abort_now = ((state_q == ISSUE) || (state_q == DRAIN)) && !bus.init_finish;

    rd_tag_pipe #(
        .ADDR_W (ADDR_W),
        .DEPTH  (RD_LATENCY)
    ) u_tag_pipe (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush_i     (abort_now),
        .push_vld_i  (state_q == ISSUE),
        .push_addr_i (addr_q),
        .out_vld_o   (tag_vld),
        .out_addr_o  (tag_addr)
    );

    // State register (address counter and drain counter move with the state)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= FIRST_A;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            drain_q <= drain_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        drain_d = drain_q;
        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = ISSUE;
                    addr_d  = FIRST_A;
                end
            end
            ISSUE: begin
                if (abort_now) begin
                    state_d = IDLE;
                end else if (addr_q == LAST_A) begin
                    // rd_address parks on LAST_ADDR through DRAIN and DONE
                    state_d = DRAIN;
                    drain_d = '0;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            DRAIN: begin
                if (abort_now) begin
                    state_d = IDLE;
                end else if (drain_q == DRAIN_LAST) begin
                    state_d = DONE;
                end else begin
                    drain_d = drain_q + 2'd1;
                end
            end
            DONE: begin
                if (bus.retest) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state_q == ISSUE) || (state_q == DRAIN);
        done = (state_q == DONE);
    end

    // Edge detector and registered one-cycle pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            init_q    <= 1'b0;
            armed_q   <= 1'b0;
            restart_q <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            init_q    <= bus.init_finish;
            armed_q   <= armed_q | ~bus.init_finish;
            restart_q <= (state_q == DONE) && bus.retest;
            abort_q   <= abort_now;
        end
    end

    // Compare / accumulate. An abort in the same cycle as a return wins, so
    // the partial results stay exactly as they were before the abort cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum_q <= '0;
            mis_q <= '0;
            bad_q <= NO_BAD;
        end else if ((state_q == IDLE) && rise) begin
            sum_q <= '0;
            mis_q <= '0;
            bad_q <= NO_BAD;
        end else if (tag_vld && !abort_now) begin
            sum_q <= sum_q + CHK_W'(bus.rd_data);
            if (bus.rd_data != tag_addr[DATA_W-1:0]) begin
                if (mis_q != '1) begin
                    mis_q <= mis_q + 1'b1;
                end
                if (bad_q == NO_BAD) begin
                    bad_q <= tag_addr;
                end
            end
        end
    end

    assign bus.rd_address     = addr_q;
    assign bus.restart        = restart_q;
    assign bus.abort          = abort_q;
    assign bus.busy           = busy;
    assign bus.done           = done;
    assign bus.pass           = done && (mis_q == '0);
    assign bus.checksum       = sum_q;
    assign bus.mismatch_count = mis_q;
    assign bus.first_bad_addr = bad_q;

endmodule
